// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_line_buffer
// Purpose  : Two-line buffer feeding a 3x3 Sobel window with column triples.
// Revision : 1.0
// ============================================================================
module sobel_line_buffer #(
    parameter int ROWS  = 480,
    parameter int COLS  = 640,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [PIX_W-1:0] d0_o,
    output logic [PIX_W-1:0] d1_o,
    output logic [PIX_W-1:0] d2_o,
    output logic             done_o,
    output logic             frame_done_o
);

    localparam int c_col_w = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_TAIL   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [c_col_w-1:0] col_q, col_d;
    logic [c_row_w-1:0] row_q, row_d;
    logic [PIX_W-1:0]   d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic               done_q, done_d;
    logic               tail_q, tail_d;
    logic               frame_done_q;

    logic [PIX_W-1:0]   mem_mid [COLS];
    logic [PIX_W-1:0]   mem_top [COLS];
    logic [PIX_W-1:0]   mid_rd;
    logic [PIX_W-1:0]   top_rd;
    logic               mid_we, top_we;
    logic               accept, col_last, row_last;

    assign ready_o  = (state_q == S_FILL) || (state_q == S_STREAM);
    assign accept   = valid_i && ready_o;
    assign col_last = (col_q == c_col_w'(COLS - 1));
    assign row_last = (row_q == c_row_w'(ROWS - 1));
    assign mid_rd   = mem_mid[col_q];
    assign top_rd   = mem_top[col_q];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        done_d  = 1'b0;
        tail_d  = 1'b0;
        mid_we  = 1'b0;
        top_we  = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    mid_we = 1'b1;
                    if (col_last) begin
                        col_d   = '0;
                        row_d   = row_q + c_row_w'(1);
                        state_d = S_STREAM;
                    end else begin
                        col_d = col_q + c_col_w'(1);
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    mid_we = 1'b1;
                    top_we = 1'b1;
                    d0_d   = pix_i;
                    d1_d   = mid_rd;
                    // On input row 1 mem_top has never been written this frame.
                    d2_d   = (row_q == c_row_w'(1)) ? '0 : top_rd;
                    done_d = 1'b1;
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            state_d = S_FLUSH;
                        end else begin
                            row_d = row_q + c_row_w'(1);
                        end
                    end else begin
                        col_d = col_q + c_col_w'(1);
                    end
                end
            end
            S_FLUSH: begin
                d0_d   = '0;
                d1_d   = mid_rd;
                d2_d   = top_rd;
                done_d = 1'b1;
                if (col_last) begin
                    col_d   = '0;
                    state_d = S_TAIL;
                end else begin
                    col_d = col_q + c_col_w'(1);
                end
            end
            S_TAIL: begin
                d0_d    = '0;
                d1_d    = '0;
                d2_d    = '0;
                done_d  = 1'b1;
                tail_d  = 1'b1;
                col_d   = '0;
                row_d   = '0;
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            col_q        <= '0;
            row_q        <= '0;
            d0_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            done_q       <= 1'b0;
            tail_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            d0_q         <= d0_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            done_q       <= done_d;
            tail_q       <= tail_d;
            frame_done_q <= tail_q;
        end
    end

    // Line memories carry no reset; stale data is masked by FILL and the row-1 gate.
    always_ff @(posedge clk) begin
        if (mid_we) begin
            mem_mid[col_q] <= pix_i;
        end
        if (top_we) begin
            mem_top[col_q] <= mid_rd;
        end
    end

    assign d0_o         = d0_q;
    assign d1_o         = d1_q;
    assign d2_o         = d2_q;
    assign done_o       = done_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_line_buffer
// Purpose  : Scoreboard bench for sobel_line_buffer at ROWS=3, COLS=4.
// Revision : 1.0
// ============================================================================
module tb_sobel_line_buffer;

    localparam int ROWS  = 3;
    localparam int COLS  = 4;
    localparam int PIX_W = 8;

    logic             clk;
    logic             rst;
    logic [PIX_W-1:0] pix_i;
    logic             valid_i;
    logic             ready_o;
    logic [PIX_W-1:0] d0_o, d1_o, d2_o;
    logic             done_o;
    logic             frame_done_o;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       tail;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   frames_seen = 0;

    sobel_line_buffer #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_i        (pix_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .d0_o         (d0_o),
        .d1_o         (d1_o),
        .d2_o         (d2_o),
        .done_o       (done_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per strobe, otherwise expects held outputs.
    exp_t last_e;
    bit   last_tail;
    int   dcount;
    initial begin
        last_e    = '0;
        last_tail = 1'b0;
        dcount    = 0;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            exp_q.delete();
            last_e    = '0;
            last_tail = 1'b0;
            dcount    = 0;
        end else begin
            if (last_tail || frame_done_o) begin
                chk("frame_done_after_tail", {31'd0, frame_done_o}, {31'd0, last_tail});
            end
            if (frame_done_o) begin
                frames_seen++;
                chk("strobes_per_frame", dcount, ROWS * COLS + 1);
                dcount = 0;
            end
            last_tail = 1'b0;
            if (done_o) begin
                dcount++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got d0=%0h d1=%0h d2=%0h required no strobe",
                             d0_o, d1_o, d2_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({d0_o, d1_o, d2_o} !== {e.d0, e.d1, e.d2}) begin
                        failures++;
                        $display("FAIL column: got d0=%0h d1=%0h d2=%0h required d0=%0h d1=%0h d2=%0h",
                                 d0_o, d1_o, d2_o, e.d0, e.d1, e.d2);
                    end
                    last_e    = e;
                    last_tail = e.tail;
                end
            end else begin
                checks++;
                if ({d0_o, d1_o, d2_o} !== {last_e.d0, last_e.d1, last_e.d2}) begin
                    failures++;
                    $display("FAIL hold: got d0=%0h d1=%0h d2=%0h required d0=%0h d1=%0h d2=%0h",
                             d0_o, d1_o, d2_o, last_e.d0, last_e.d1, last_e.d2);
                end
            end
        end
    end

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        logic [7:0] off;
        off = 8'(r * 16 + c);
        return base + off;
    endfunction

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d, input bit t);
        exp_t e;
        e.d0 = a; e.d1 = b; e.d2 = d; e.tail = t;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] p);
        int budget;
        budget  = 0;
        pix_i   = p;
        valid_i = 1'b1;
        while (!ready_o) begin
            @(negedge clk);
            budget++;
            if (budget > 100) begin
                failures++;
                $display("FAIL accept_timeout: got ready_o=0 required ready_o=1 within 100 cycles");
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] base, input bit gap);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r >= 1) begin
                    push(pix(base, r, c), pix(base, r - 1, c),
                         (r >= 2) ? pix(base, r - 2, c) : 8'h00, 1'b0);
                end
                if (r == ROWS - 1 && c == COLS - 1) begin
                    for (int f = 0; f < COLS; f++) begin
                        push(8'h00, pix(base, ROWS - 1, f), pix(base, ROWS - 2, f), 1'b0);
                    end
                    push(8'h00, 8'h00, 8'h00, 1'b1);
                end
                send(pix(base, r, c));
                if (gap && r == 2 && c == 1) begin
                    valid_i = 1'b0;
                    for (int g = 0; g < 3; g++) begin
                        @(negedge clk);
                        chk("gap_done_low", {31'd0, done_o}, 32'd0);
                        chk("gap_hold_d0", {24'd0, d0_o}, {24'd0, pix(base, 2, 1)});
                        chk("gap_hold_d1", {24'd0, d1_o}, {24'd0, pix(base, 1, 1)});
                    end
                end
            end
        end
        chk("flush_ready_low", {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: got no end of run required end within 5000 cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        rst     = 1'b1;
        valid_i = 1'b0;
        pix_i   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done_o}, 32'd0);
        chk("reset_data", {8'd0, d0_o, d1_o, d2_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Continuous frame.
        run_frame(8'h00, 1'b0);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);

        // Frame with a 3-cycle input gap mid row 2.
        run_frame(8'h40, 1'b0 | 1'b1);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);

        // Partial frame aborted by reset at row 2 col 1.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r >= 1) push(pix(8'h60, r, c), pix(8'h60, r - 1, c), 8'h00, 1'b0);
                send(pix(8'h60, r, c));
            end
        end
        push(pix(8'h60, 2, 0), pix(8'h60, 1, 0), pix(8'h60, 0, 0), 1'b0);
        send(pix(8'h60, 2, 0));
        pix_i = pix(8'h60, 2, 1);
        rst   = 1'b1;
        @(negedge clk);
        chk("midreset_ready", {31'd0, ready_o}, 32'd1);
        chk("midreset_done", {31'd0, done_o}, 32'd0);
        chk("midreset_data", {8'd0, d0_o, d1_o, d2_o}, 32'd0);
        rst     = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);

        // Back-to-back frames with valid_i held high through flush and tail.
        run_frame(8'h00, 1'b0);
        run_frame(8'h80, 1'b0);
        valid_i = 1'b0;

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("frames_completed", frames_seen, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sobel_line_buffer.md
Name: sobel_line_buffer

Overview:
- Upstream feeder of the 3x3 Sobel window stage.
- Accepts a raster pixel stream, stores the two previous lines, and emits one vertically aligned column triple per strobe: bottom, middle and top rows around the centre row.
- Flushes the last image line internally with a zero bottom row, then appends one zero tail strobe so the downstream shift window can complete the final pixel.

Parameters:
- ROWS, 480, image height in lines.
- COLS, 640, image width in pixels.
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pix_i  in  PIX_W  input pixel, raster order
- valid_i  in  1  pix_i valid
- ready_o  out  1  block accepts pix_i this cycle
- d0_o  out  PIX_W  bottom row pixel (row r+1)
- d1_o  out  PIX_W  middle/centre row pixel (row r)
- d2_o  out  PIX_W  top row pixel (row r-1)
- done_o  out  1  one-cycle strobe; d0_o..d2_o hold a new column
- frame_done_o  out  1  one-cycle pulse after the tail strobe

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Storage:
  - Two COLS x PIX_W line memories: mem_mid holds row r, mem_top holds row r-1.
  - One read and one write per memory per cycle at the same column address.
- Counters:
  - col_cnt counts 0..COLS-1 and row_cnt counts 0..ROWS-1; both are clog2-wide.
  - Both advance only on an accepted pixel (valid_i && ready_o) or on a FLUSH/TAIL step.
  - col_cnt wraps at COLS-1 and increments row_cnt.
- Accept: a pixel is accepted only when valid_i && ready_o. ready_o=1 in FILL and STREAM, 0 in FLUSH and TAIL.
- States:
  - FILL (input row 0):
    - Accepted pixel is written to mem_mid[col_cnt]; no output.
    - At col COLS-1 go to STREAM.
  - STREAM (input rows 1..ROWS-1, centre row = input row - 1). Each accepted pixel p at column c gives:
    - d0_o=p, d1_o=mem_mid[c], d2_o=mem_top[c].
    - d2_o is forced to 0 while the input row is 1.
    - mem_top[c]<=mem_mid[c] and mem_mid[c]<=p.
    - At row ROWS-1, col COLS-1 go to FLUSH.
  - FLUSH (centre row ROWS-1):
    - COLS consecutive cycles, one column each, no input.
    - d0_o=0, d1_o=mem_mid[c], d2_o=mem_top[c], done_o each cycle.
    - Then go to TAIL.
  - TAIL: one cycle with d0_o=d1_o=d2_o=0 and done_o=1. Next cycle: frame_done_o=1, counters cleared, go to FILL.
- Latency: outputs and done_o are registered, one cycle after acceptance (STREAM) or the step (FLUSH/TAIL).
- done_o low: d0_o..d2_o hold their previous values.
- Strobe count: exactly (ROWS-1)*COLS in STREAM + COLS in FLUSH + 1 in TAIL = ROWS*COLS+1 per frame.
- Gapless output: done_o is gapless whenever valid_i is continuously high during STREAM. Input gaps produce equal output gaps; the downstream window requires a gapless stream, so sources must not stall mid-frame.
- Reset values: d0_o=d1_o=d2_o=0, done_o=0, frame_done_o=0, ready_o=1, state FILL, counters 0.
- Memories are not reset. Stale contents are never observable, because FILL rewrites mem_mid and d2_o is gated on input row 1.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as row 0, col 0.
- valid_i high during FLUSH/TAIL: the pixel is not consumed; the source holds it.
- Frames run back-to-back: the first pixel of the next frame is accepted the cycle after TAIL.

Test Plan (ROWS=3, COLS=4, pix = row*16+col):
- Continuous frame, valid_i always 1 -> no done_o during row 0. First done_o appears the cycle after pixel 0x10 is accepted: d0=0x10, d1=0x00, d2=0x00.
- Same frame, pixel 0x23 accepted -> next cycle d0=0x23, d1=0x13, d2=0x03.
- Flush phase, first FLUSH column -> d0=0x00, d1=0x20, d2=0x10 with ready_o=0. Then a TAIL strobe with all outputs 0, then frame_done_o=1. Total done_o count per frame is 13.
- valid_i low for 3 cycles mid-row 2 -> done_o low 3 cycles, outputs held, no column skipped, values unchanged.
- rst asserted at row 2 col 1 -> next cycle all outputs 0, ready_o=1. A new frame starting 0x00 produces the correct first column with d2=0 despite stale memory.
- Two back-to-back frames (second uses pix+0x80), valid_i held high through FLUSH -> no pixel lost. The second frame's first done_o gives d0=0x90, d1=0x80, d2=0.
